// File: rtl/axi4_slave_ram.sv
// axi4_slave_ram
//   AXI4 responder backed by a single-port block RAM. Serves one INCR burst
//   at a time (write or read). It implements only the signal subset driven by
//   the UART-command master: no IDs, no strobes, no resp fields.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   awvalid/awready/awaddr/awlen  write address channel (awlen = beats-1)
//   wvalid/wready/wlast/wdata     write data channel
//   bvalid/bready                 write response channel
//   arvalid/arready/araddr/arlen  read address channel (arlen = beats-1)
//   rvalid/rready/rlast/rdata     read data channel
//   proto_err                     high on an accepted W beat whose wlast
//                                 disagrees with the awlen-derived last beat
//
// Addresses are word addresses. Only addr[MEM_ASIZE-1:0] index the RAM, so
// the upper bits alias, and a burst running past the top wraps to 0.
module axi4_slave_ram #(
  parameter int A_WIDTH   = 26,
  parameter int D_WIDTH   = 16,
  parameter int MEM_ASIZE = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               awvalid,
  output logic               awready,
  input  logic [A_WIDTH-1:0] awaddr,
  input  logic [7:0]         awlen,
  input  logic               wvalid,
  output logic               wready,
  input  logic               wlast,
  input  logic [D_WIDTH-1:0] wdata,
  output logic               bvalid,
  input  logic               bready,
  input  logic               arvalid,
  output logic               arready,
  input  logic [A_WIDTH-1:0] araddr,
  input  logic [7:0]         arlen,
  output logic               rvalid,
  input  logic               rready,
  output logic               rlast,
  output logic [D_WIDTH-1:0] rdata,
  output logic               proto_err
);

  localparam int unsigned DEPTH = 1 << MEM_ASIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RADDR_PF,
    S_RDATA
  } state_e;

  state_e               state_q, state_d;
  logic [MEM_ASIZE-1:0] ptr_q, ptr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           len_q, len_d;
  logic [D_WIDTH-1:0]   rdata_q;
  // Low for the single cycle after reset, so every output reads 0 then even
  // though the FSM already sits in IDLE.
  logic                 live_q;
  logic                 mem_we, mem_re;
  logic                 last_beat;
  logic                 aw_hs, ar_hs, w_hs, r_hs;

  logic [D_WIDTH-1:0] mem [DEPTH];

  // Upper address bits deliberately alias onto the RAM.
  wire unused_addr_bits = ^{awaddr[A_WIDTH-1:MEM_ASIZE], araddr[A_WIDTH-1:MEM_ASIZE]};

  // cnt is compared before it is incremented, so len=255 ends on cnt=255
  // and the 8-bit counter never has to hold 256.
  assign last_beat = (cnt_q == len_q);

  assign aw_hs = awvalid & awready;
  assign ar_hs = arvalid & arready;
  assign w_hs  = wvalid  & wready;
  assign r_hs  = rvalid  & rready;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath control.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          ptr_d   = awaddr[MEM_ASIZE-1:0];
          len_d   = awlen;
          cnt_d   = '0;
          state_d = S_WDATA;
        end else if (ar_hs) begin
          ptr_d   = araddr[MEM_ASIZE-1:0];
          len_d   = arlen;
          cnt_d   = '0;
          state_d = S_RADDR_PF;
        end
      end
      S_WDATA: begin
        if (w_hs) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          cnt_d  = cnt_q + 8'd1;
          if (last_beat) state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (bready) state_d = S_IDLE;
      end
      S_RADDR_PF: begin
        // First beat is read into the output register; ptr then runs one
        // word ahead of the beat being presented.
        mem_re  = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        if (r_hs) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            // Reading the next word on the handshake edge gives one beat
            // per cycle with no bubble, and holds rdata while stalled.
            mem_re = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    awready   = (state_q == S_IDLE) & live_q;
    arready   = (state_q == S_IDLE) & live_q & ~awvalid;
    wready    = (state_q == S_WDATA);
    bvalid    = (state_q == S_WRESP);
    rvalid    = (state_q == S_RDATA);
    rlast     = (state_q == S_RDATA) & last_beat;
    rdata     = rdata_q;
    proto_err = (state_q == S_WDATA) & wvalid & (wlast != last_beat);
  end

  // Burst bookkeeping and read output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      rdata_q <= '0;
      live_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      live_q <= 1'b1;
      if (mem_re) rdata_q <= mem[ptr_q];
    end
  end

  // NOTE: the RAM array has no reset; contents must survive rst and a reset
  // port would prevent block-RAM inference.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= wdata;
  end

endmodule
